// File: rtl/rs_pkg.sv
// Shared sizing and entry layout for the ALU reservation station.
package rs_pkg;

  localparam int WIDTH = 31;
  localparam int RS    = 3;
  localparam int TAG   = 4;
  localparam int CTRL  = 3;

  typedef logic [TAG:0] rob_tag_t;

  typedef struct packed {
    logic            busy;
    logic            rdy1;
    logic            rdy2;
    logic [WIDTH:0]  val1;
    logic [WIDTH:0]  val2;
    rob_tag_t        tag1;
    rob_tag_t        tag2;
    logic [CTRL:0]   ctrl;
    rob_tag_t        dest;
  } rs_entry_t;

endpackage

// File: rtl/rs_priority_arbiter.sv
// Fixed-priority one-hot arbiter: lowest requesting index wins when enabled.
module rs_priority_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0] req,
  input  logic         en,
  output logic [N-1:0] gnt
);

  // Isolate the lowest set bit: req & -req.
  always_comb begin
    gnt = '0;
    if (en) gnt = req & (~req + N'(1));
  end

endmodule

// File: rtl/alu_reservation_station.sv
// ALU reservation station: buffers dispatched instructions, captures CDB results, issues one ready entry per cycle.
module alu_reservation_station
  import rs_pkg::*;
#(
  parameter int WIDTH = rs_pkg::WIDTH,
  parameter int RS    = rs_pkg::RS,
  parameter int TAG   = rs_pkg::TAG,
  parameter int CTRL  = rs_pkg::CTRL
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   dispatchValid,
  input  logic [CTRL:0]          dispatchCtrl,
  input  logic [TAG:0]           dispatchDest,
  input  logic                   dispatchRdy1,
  input  logic                   dispatchRdy2,
  input  logic [WIDTH:0]         dispatchSrc1,
  input  logic [WIDTH:0]         dispatchSrc2,
  input  logic [TAG:0]           dispatchTag1,
  input  logic [TAG:0]           dispatchTag2,
  input  logic                   cdbValid,
  input  logic [TAG:0]           cdbTag,
  input  logic [WIDTH:0]         cdbData,
  input  logic                   fuReady,
  output logic                   rsFull,
  output logic [RS:0]            grants,
  output logic [RS:0][WIDTH:0]   sourceOperands1,
  output logic [RS:0][WIDTH:0]   sourceOperands2,
  output logic [RS:0][CTRL:0]    entryCtrl,
  output logic [RS:0][TAG:0]     entryDest
);

  rs_entry_t   ent [0:RS];
  rs_entry_t   disp_entry;
  logic [RS:0] busy;
  logic [RS:0] ready;
  logic [RS:0] free_gnt;
  logic        alloc;

  always_comb begin
    busy  = '0;
    ready = '0;
    for (int unsigned i = 0; i <= RS; i++) begin
      busy[i]            = ent[i].busy;
      ready[i]           = ent[i].busy & ent[i].rdy1 & ent[i].rdy2;
      sourceOperands1[i] = ent[i].val1;
      sourceOperands2[i] = ent[i].val2;
      entryCtrl[i]       = ent[i].ctrl;
      entryDest[i]       = ent[i].dest;
    end
  end

  assign rsFull = &busy;
  assign alloc  = dispatchValid & ~rsFull & ~flush;

  rs_priority_arbiter #(.N(RS+1)) u_free_arb (
    .req (~busy),
    .en  (1'b1),
    .gnt (free_gnt)
  );

  rs_priority_arbiter #(.N(RS+1)) u_issue_arb (
    .req (ready),
    .en  (fuReady),
    .gnt (grants)
  );

  // Incoming entry, with same-cycle CDB bypass for operands not yet ready.
  always_comb begin
    disp_entry      = '0;
    disp_entry.busy = 1'b1;
    disp_entry.ctrl = dispatchCtrl;
    disp_entry.dest = dispatchDest;
    disp_entry.tag1 = dispatchTag1;
    disp_entry.tag2 = dispatchTag2;
    disp_entry.rdy1 = dispatchRdy1;
    disp_entry.rdy2 = dispatchRdy2;
    disp_entry.val1 = dispatchSrc1;
    disp_entry.val2 = dispatchSrc2;
    if (!dispatchRdy1 && cdbValid && cdbTag == dispatchTag1) begin
      disp_entry.rdy1 = 1'b1;
      disp_entry.val1 = cdbData;
    end
    if (!dispatchRdy2 && cdbValid && cdbTag == dispatchTag2) begin
      disp_entry.rdy2 = 1'b1;
      disp_entry.val2 = cdbData;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i <= RS; i++) ent[i] <= '0;
    end else if (flush) begin
      for (int unsigned i = 0; i <= RS; i++) begin
        ent[i].busy <= 1'b0;
        ent[i].rdy1 <= 1'b0;
        ent[i].rdy2 <= 1'b0;
      end
    end else begin
      for (int unsigned i = 0; i <= RS; i++) begin
        if (grants[i]) ent[i].busy <= 1'b0;
        if (ent[i].busy && !ent[i].rdy1 && cdbValid && ent[i].tag1 == cdbTag) begin
          ent[i].rdy1 <= 1'b1;
          ent[i].val1 <= cdbData;
        end
        if (ent[i].busy && !ent[i].rdy2 && cdbValid && ent[i].tag2 == cdbTag) begin
          ent[i].rdy2 <= 1'b1;
          ent[i].val2 <= cdbData;
        end
        // Free slots are never busy, so allocation cannot collide with issue or wakeup.
        if (alloc && free_gnt[i]) ent[i] <= disp_entry;
      end
    end
  end

endmodule

// File: tb/tb_alu_reservation_station.sv
// Directed self-checking bench for alu_reservation_station.
module tb_alu_reservation_station;

  logic             clk = 1'b0;
  logic             reset, flush;
  logic             dispatchValid;
  logic [3:0]       dispatchCtrl;
  logic [4:0]       dispatchDest;
  logic             dispatchRdy1, dispatchRdy2;
  logic [31:0]      dispatchSrc1, dispatchSrc2;
  logic [4:0]       dispatchTag1, dispatchTag2;
  logic             cdbValid;
  logic [4:0]       cdbTag;
  logic [31:0]      cdbData;
  logic             fuReady;
  logic             rsFull;
  logic [3:0]       grants;
  logic [3:0][31:0] sourceOperands1, sourceOperands2;
  logic [3:0][3:0]  entryCtrl;
  logic [3:0][4:0]  entryDest;

  int errors = 0;
  int checks = 0;

  alu_reservation_station dut (
    .clk             (clk),
    .reset           (reset),
    .flush           (flush),
    .dispatchValid   (dispatchValid),
    .dispatchCtrl    (dispatchCtrl),
    .dispatchDest    (dispatchDest),
    .dispatchRdy1    (dispatchRdy1),
    .dispatchRdy2    (dispatchRdy2),
    .dispatchSrc1    (dispatchSrc1),
    .dispatchSrc2    (dispatchSrc2),
    .dispatchTag1    (dispatchTag1),
    .dispatchTag2    (dispatchTag2),
    .cdbValid        (cdbValid),
    .cdbTag          (cdbTag),
    .cdbData         (cdbData),
    .fuReady         (fuReady),
    .rsFull          (rsFull),
    .grants          (grants),
    .sourceOperands1 (sourceOperands1),
    .sourceOperands2 (sourceOperands2),
    .entryCtrl       (entryCtrl),
    .entryDest       (entryDest)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic disp(input logic r1, input logic [31:0] s1, input logic [4:0] t1,
                      input logic r2, input logic [31:0] s2, input logic [4:0] t2,
                      input logic [4:0] dest);
    dispatchValid = 1'b1;
    dispatchRdy1  = r1; dispatchSrc1 = s1; dispatchTag1 = t1;
    dispatchRdy2  = r2; dispatchSrc2 = s2; dispatchTag2 = t2;
    dispatchDest  = dest;
    dispatchCtrl  = dest[3:0];
  endtask

  task automatic idle();
    dispatchValid = 1'b0;
    cdbValid      = 1'b0;
    flush         = 1'b0;
  endtask

  task automatic cdb(input logic [4:0] t, input logic [31:0] d);
    cdbValid = 1'b1; cdbTag = t; cdbData = d;
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; fuReady = 1'b1;
    dispatchValid = 1'b0; dispatchCtrl = '0; dispatchDest = '0;
    dispatchRdy1 = 1'b0; dispatchRdy2 = 1'b0; dispatchSrc1 = '0; dispatchSrc2 = '0;
    dispatchTag1 = '0; dispatchTag2 = '0; cdbValid = 1'b0; cdbTag = '0; cdbData = '0;
    tick(); tick();
    reset = 1'b0;
    chk("reset_full", 32'(rsFull), 32'd0);
    chk("reset_grants", 32'(grants), 32'd0);
    chk("reset_op1_0", sourceOperands1[0], 32'd0);

    // Both operands ready at dispatch
    disp(1'b1, 32'd5, 5'd0, 1'b1, 32'd7, 5'd0, 5'd1);
    tick(); idle();
    chk("t1_grant", 32'(grants), 32'h1);
    chk("t1_op1", sourceOperands1[0], 32'd5);
    chk("t1_op2", sourceOperands2[0], 32'd7);
    chk("t1_dest", 32'(entryDest[0]), 32'd1);
    chk("t1_ctrl", 32'(entryCtrl[0]), 32'd1);
    tick();
    chk("t1_freed", 32'(grants), 32'h0);

    // Operand 1 woken by a later broadcast
    disp(1'b0, 32'd0, 5'd3, 1'b1, 32'd1, 5'd0, 5'd2);
    tick(); idle();
    chk("t2_wait_a", 32'(grants), 32'h0);
    tick();
    chk("t2_wait_b", 32'(grants), 32'h0);
    cdb(5'd3, 32'hDEAD);
    #1 chk("t2_bcast_cycle", 32'(grants), 32'h0);
    tick(); idle();
    chk("t2_grant", 32'(grants), 32'h1);
    chk("t2_op1", sourceOperands1[0], 32'hDEAD);
    tick();
    chk("t2_freed", 32'(grants), 32'h0);

    // Fill all entries, drop an extra dispatch, wake entry 2
    for (int i = 0; i < 4; i++) begin
      disp(1'b0, 32'd0, 5'(10 + i), 1'b1, 32'd0, 5'd0, 5'(20 + i));
      tick();
    end
    idle();
    chk("t3_full", 32'(rsFull), 32'd1);
    disp(1'b1, 32'd1, 5'd0, 1'b1, 32'd1, 5'd0, 5'd9);
    tick(); idle();
    chk("t3_drop_grants", 32'(grants), 32'h0);
    chk("t3_drop_dest0", 32'(entryDest[0]), 32'd20);
    chk("t3_drop_dest3", 32'(entryDest[3]), 32'd23);
    cdb(5'd12, 32'h1234);
    tick(); idle();
    chk("t3_grant", 32'(grants), 32'h4);
    chk("t3_full_in_grant", 32'(rsFull), 32'd1);
    chk("t3_op1_2", sourceOperands1[2], 32'h1234);
    tick();
    chk("t3_not_full", 32'(rsFull), 32'd0);
    chk("t3_after", 32'(grants), 32'h0);
    flush = 1'b1;
    tick(); idle();

    // fuReady gating and priority order
    fuReady = 1'b0;
    disp(1'b0, 32'd0, 5'd15, 1'b1, 32'd0, 5'd0, 5'd1); tick();
    disp(1'b1, 32'd11, 5'd0, 1'b1, 32'd12, 5'd0, 5'd2); tick();
    disp(1'b0, 32'd0, 5'd15, 1'b1, 32'd0, 5'd0, 5'd3); tick();
    disp(1'b1, 32'd31, 5'd0, 1'b1, 32'd32, 5'd0, 5'd4); tick();
    idle();
    chk("t4_blocked", 32'(grants), 32'h0);
    fuReady = 1'b1;
    #1 chk("t4_first", 32'(grants), 32'h2);
    tick();
    chk("t4_second", 32'(grants), 32'h8);
    chk("t4_op1_3", sourceOperands1[3], 32'd31);
    tick();
    chk("t4_done", 32'(grants), 32'h0);
    flush = 1'b1;
    tick(); idle();

    // Dispatch-cycle bypass
    disp(1'b0, 32'd0, 5'd6, 1'b1, 32'd4, 5'd0, 5'd7);
    cdb(5'd6, 32'd9);
    tick(); idle();
    chk("t5_grant", 32'(grants), 32'h1);
    chk("t5_op1", sourceOperands1[0], 32'd9);
    tick();

    // Both operands wake on one broadcast
    disp(1'b0, 32'd0, 5'd7, 1'b0, 32'd0, 5'd7, 5'd8);
    tick(); idle();
    chk("dual_wait", 32'(grants), 32'h0);
    cdb(5'd7, 32'h55);
    tick(); idle();
    chk("dual_grant", 32'(grants), 32'h1);
    chk("dual_op2", sourceOperands2[0], 32'h55);
    tick();

    // Flush with three busy entries and a simultaneous dispatch
    for (int i = 0; i < 3; i++) begin
      disp(1'b0, 32'd0, 5'd14, 1'b1, 32'd0, 5'd0, 5'(i));
      tick();
    end
    disp(1'b1, 32'd1, 5'd0, 1'b1, 32'd1, 5'd0, 5'd5);
    flush = 1'b1;
    tick(); idle();
    chk("t6_full", 32'(rsFull), 32'd0);
    chk("t6_grants", 32'(grants), 32'h0);
    tick();
    chk("t6_not_stored", 32'(grants), 32'h0);
    cdb(5'd14, 32'h77);
    tick(); idle();
    chk("t6_no_wake", 32'(grants), 32'h0);

    // Reset mid-operation discards entries and zeroes fields
    fuReady = 1'b0;
    disp(1'b1, 32'hAB, 5'd0, 1'b1, 32'hCD, 5'd0, 5'd3);
    tick(); idle();
    reset = 1'b1;
    tick();
    reset = 1'b0; fuReady = 1'b1;
    #1 chk("rst_grants", 32'(grants), 32'h0);
    chk("rst_op1", sourceOperands1[0], 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
